store_checker: RTL

//  Synthesizable self-check monitor on the core's data-memory write bus (MemWrite/DataAdr/WriteData).

---
 rtl/store_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/store_checker.sv
// Self-check monitor for the core's data-memory write bus: compares observed stores
// against a table of expected (address, data) pairs and latches a pass/fail verdict.
module store_checker #(
  parameter int DW       = 32,
  parameter int DEPTH    = 8,
  parameter int IN_ORDER = 1,
  parameter int IGN_LO   = 96,
  parameter int IGN_HI   = 96,
  parameter int TIMEOUT  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [DW-1:0]            DataAdr,
  input  logic [DW-1:0]            WriteData,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [DW-1:0]            exp_addr,
  input  logic [DW-1:0]            exp_data,
  input  logic [$clog2(DEPTH):0]   n_exp,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [DW-1:0]            fail_addr,
  output logic [DW-1:0]            fail_data,
  output logic [15:0]              store_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;
  localparam logic [DW-1:0] IGN_LO_V = DW'(IGN_LO);
  localparam logic [DW-1:0] IGN_HI_V = DW'(IGN_HI);
  localparam logic [31:0]   TO_V     = 32'(TIMEOUT);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t        state, state_n;
  logic [DW-1:0] tbl_addr [DEPTH];
  logic [DW-1:0] tbl_data [DEPTH];
  logic [NW-1:0] n_lat, n_lat_n, mcnt, mcnt_n;
  logic [DEPTH-1:0] mask, mask_n;
  logic [31:0]   timer, timer_n;
  logic [15:0]   cnt_n;
  logic [1:0]    code_n;
  logic [DW-1:0] faddr_n, fdata_n;
  logic          ignored, hit;
  logic [IW-1:0] hit_idx, ptr;
  logic [1:0]    err_code;

  // The table has no reset; entries only change while no check is running.
  always_ff @(posedge clk) begin
    if (exp_we && state != ST_RUN) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
    end
  end

  // In order mode the match count doubles as the table pointer.
  always_comb begin
    ignored = (DataAdr >= IGN_LO_V) && (DataAdr <= IGN_HI_V);
    ptr     = mcnt[IW-1:0];
    hit     = 1'b0;
    hit_idx = '0;
    if (IN_ORDER != 0) begin
      hit     = (tbl_addr[ptr] == DataAdr);
      hit_idx = ptr;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (NW'(i) < n_lat && !mask[i] && tbl_addr[i] == DataAdr) begin
          hit     = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end
    err_code = 2'd0;
    if (!hit)
      err_code = 2'd1;
    else if (tbl_data[hit_idx] != WriteData)
      err_code = 2'd2;
  end

  always_comb begin
    state_n = state;
    n_lat_n = n_lat;
    mcnt_n  = mcnt;
    mask_n  = mask;
    timer_n = timer;
    cnt_n   = store_cnt;
    code_n  = fail_code;
    faddr_n = fail_addr;
    fdata_n = fail_data;
    case (state)
      ST_RUN: begin
        timer_n = timer + 32'd1;
        if (mcnt == n_lat) begin
          state_n = ST_PASS;
        end else begin
          if (MemWrite && !ignored) begin
            if (store_cnt != 16'hFFFF)
              cnt_n = store_cnt + 16'd1;
            if (err_code != 2'd0) begin
              state_n = ST_FAIL;
              code_n  = err_code;
              faddr_n = DataAdr;
              fdata_n = WriteData;
            end else begin
              mcnt_n          = mcnt + 1'b1;
              mask_n[hit_idx] = 1'b1;
            end
          end
          // Completion beats a timeout landing on the same edge.
          if (state_n != ST_FAIL) begin
            if (mcnt_n == n_lat)
              state_n = ST_PASS;
            else if (TIMEOUT != 0 && timer_n == TO_V) begin
              state_n = ST_FAIL;
              code_n  = 2'd3;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_n = ST_RUN;
          n_lat_n = (n_exp > DEPTH_N) ? DEPTH_N : n_exp;
          mcnt_n  = '0;
          mask_n  = '0;
          timer_n = '0;
          cnt_n   = '0;
          code_n  = 2'd0;
          faddr_n = '0;
          fdata_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      n_lat     <= '0;
      mcnt      <= '0;
      mask      <= '0;
      timer     <= '0;
      store_cnt <= '0;
      fail_code <= 2'd0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_n;
      n_lat     <= n_lat_n;
      mcnt      <= mcnt_n;
      mask      <= mask_n;
      timer     <= timer_n;
      store_cnt <= cnt_n;
      fail_code <= code_n;
      fail_addr <= faddr_n;
      fail_data <= fdata_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);
  assign done = pass || fail;

endmodule
